// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use/RAW stall detection, branch redirect flush,
// EX operand forwarding selects and saturating stall/flush performance counters.
module hazard_unit #(
  parameter int unsigned FORWARDING = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [4:0]       rs1_ex,
  input  logic [4:0]       rs2_ex,
  input  logic [4:0]       rd_ex,
  input  logic             reg_write_ex,
  input  logic             load_ex,
  input  logic [4:0]       rd_mem,
  input  logic             reg_write_mem,
  input  logic [4:0]       rd_wb,
  input  logic             reg_write_wb,
  input  logic             redirect_ex,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    SHADOW = 2'd2
  } state_t;

  localparam logic [1:0]       SEL_RF  = 2'd0;
  localparam logic [1:0]       SEL_MEM = 2'd1;
  localparam logic [1:0]       SEL_WB  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;

  logic id_match_ex;
  logic id_match_mem;
  logic load_use;
  logic raw_hazard;
  logic hazard;
  logic redirect_eff;

  // x0 is hard-wired to zero, so it never carries a dependency.
  function automatic logic src_match(input logic [4:0] src, input logic used,
                                     input logic [4:0] dst, input logic we);
    return used && we && (src == dst) && (src != 5'd0);
  endfunction

  always_comb begin
    id_match_ex  = src_match(rs1_id, rs1_used_id, rd_ex, reg_write_ex) ||
                   src_match(rs2_id, rs2_used_id, rd_ex, reg_write_ex);
    id_match_mem = src_match(rs1_id, rs1_used_id, rd_mem, reg_write_mem) ||
                   src_match(rs2_id, rs2_used_id, rd_mem, reg_write_mem);
    load_use     = load_ex && id_match_ex;
    raw_hazard   = id_match_ex || id_match_mem;
    hazard       = (FORWARDING != 0) ? load_use : raw_hazard;
    redirect_eff = redirect_ex && (state != SHADOW);
  end

  // A redirect squashes the would-be stalled instruction, so it wins over any hazard.
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    fwd_a_sel    = SEL_RF;
    fwd_b_sel    = SEL_RF;
    if (!rst) begin
      if (redirect_eff) begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end else if (hazard) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end
      if (FORWARDING != 0) begin
        if (src_match(rs1_ex, 1'b1, rd_mem, reg_write_mem))
          fwd_a_sel = SEL_MEM;
        else if (src_match(rs1_ex, 1'b1, rd_wb, reg_write_wb))
          fwd_a_sel = SEL_WB;
        if (src_match(rs2_ex, 1'b1, rd_mem, reg_write_mem))
          fwd_b_sel = SEL_MEM;
        else if (src_match(rs2_ex, 1'b1, rd_wb, reg_write_wb))
          fwd_b_sel = SEL_WB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (redirect_eff) begin
        state <= SHADOW;
      end else begin
        case (state)
          RUN:     state <= hazard ? STALL : RUN;
          STALL:   state <= hazard ? STALL : RUN;
          SHADOW:  state <= RUN;
          default: state <= RUN;
        endcase
      end
      if (stall_pc && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_if_id && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: table of cycle vectors through a scoreboard
// queue, run against forwarding, stalling and narrow-counter builds.
module tb_hazard_unit;

  typedef struct {
    int         dut;
    int         idx;
    logic       rst, redir;
    logic [4:0] rs1_id;  logic u1;
    logic [4:0] rs2_id;  logic u2;
    logic [4:0] rs1_ex, rs2_ex, rd_ex;
    logic       we_ex, ld_ex;
    logic [4:0] rd_mem;  logic we_mem;
    logic [4:0] rd_wb;   logic we_wb;
    logic       st, bub, fl;
    logic [1:0] fa, fb;
    int         scnt, fcnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs1_id = '0, rs2_id = '0, rs1_ex = '0, rs2_ex = '0;
  logic [4:0] rd_ex = '0, rd_mem = '0, rd_wb = '0;
  logic rs1_used_id = 1'b0, rs2_used_id = 1'b0;
  logic reg_write_ex = 1'b0, load_ex = 1'b0, reg_write_mem = 1'b0;
  logic reg_write_wb = 1'b0, redirect_ex = 1'b0;

  logic stall_pc_f, stall_if_id_f, bubble_f, flush_f;
  logic [1:0] fa_f, fb_f;
  logic [31:0] scnt_f, fcnt_f;
  logic stall_pc_n, stall_if_id_n, bubble_n, flush_n;
  logic [1:0] fa_n, fb_n;
  logic [31:0] scnt_n, fcnt_n;
  logic stall_pc_s, stall_if_id_s, bubble_s, flush_s;
  logic [1:0] fa_s, fb_s;
  logic [3:0] scnt_s, fcnt_s;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  hazard_unit #(.FORWARDING(1), .CNT_W(32)) dut_f (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .reg_write_ex(reg_write_ex),
    .load_ex(load_ex), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
    .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .redirect_ex(redirect_ex),
    .stall_pc(stall_pc_f), .stall_if_id(stall_if_id_f), .bubble_id_ex(bubble_f),
    .flush_if_id(flush_f), .fwd_a_sel(fa_f), .fwd_b_sel(fb_f),
    .stall_cnt(scnt_f), .flush_cnt(fcnt_f));

  hazard_unit #(.FORWARDING(0), .CNT_W(32)) dut_n (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .reg_write_ex(reg_write_ex),
    .load_ex(load_ex), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
    .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .redirect_ex(redirect_ex),
    .stall_pc(stall_pc_n), .stall_if_id(stall_if_id_n), .bubble_id_ex(bubble_n),
    .flush_if_id(flush_n), .fwd_a_sel(fa_n), .fwd_b_sel(fb_n),
    .stall_cnt(scnt_n), .flush_cnt(fcnt_n));

  hazard_unit #(.FORWARDING(1), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .reg_write_ex(reg_write_ex),
    .load_ex(load_ex), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
    .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .redirect_ex(redirect_ex),
    .stall_pc(stall_pc_s), .stall_if_id(stall_if_id_s), .bubble_id_ex(bubble_s),
    .flush_if_id(flush_s), .fwd_a_sel(fa_s), .fwd_b_sel(fb_s),
    .stall_cnt(scnt_s), .flush_cnt(fcnt_s));

  function automatic vec_t mk(int d, logic r, logic rd,
                              logic [4:0] a1, logic b1, logic [4:0] a2, logic b2,
                              logic [4:0] e1, logic [4:0] e2, logic [4:0] de,
                              logic we, logic ld, logic [4:0] dm, logic wm,
                              logic [4:0] dw, logic ww,
                              logic st, logic bub, logic fl, logic [1:0] fa,
                              logic [1:0] fb, int sc, int fc);
    vec_t v;
    v.dut = d; v.idx = 0; v.rst = r; v.redir = rd;
    v.rs1_id = a1; v.u1 = b1; v.rs2_id = a2; v.u2 = b2;
    v.rs1_ex = e1; v.rs2_ex = e2; v.rd_ex = de; v.we_ex = we; v.ld_ex = ld;
    v.rd_mem = dm; v.we_mem = wm; v.rd_wb = dw; v.we_wb = ww;
    v.st = st; v.bub = bub; v.fl = fl; v.fa = fa; v.fb = fb;
    v.scnt = sc; v.fcnt = fc;
    return v;
  endfunction

  task automatic compare(input string name, input int idx, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL v%0d.%s got=%0d expected=%0d", idx, name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; redirect_ex = v.redir;
    rs1_id = v.rs1_id; rs1_used_id = v.u1; rs2_id = v.rs2_id; rs2_used_id = v.u2;
    rs1_ex = v.rs1_ex; rs2_ex = v.rs2_ex; rd_ex = v.rd_ex;
    reg_write_ex = v.we_ex; load_ex = v.ld_ex;
    rd_mem = v.rd_mem; reg_write_mem = v.we_mem;
    rd_wb = v.rd_wb; reg_write_wb = v.we_wb;
    sb.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    logic sp, si, bb, fl;
    logic [1:0] a, b;
    int sc, fc;
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty got=0 expected=1");
      return;
    end
    e = sb.pop_front();
    case (e.dut)
      1:       begin sp = stall_pc_n; si = stall_if_id_n; bb = bubble_n; fl = flush_n;
                     a = fa_n; b = fb_n; sc = int'(scnt_n); fc = int'(fcnt_n); end
      2:       begin sp = stall_pc_s; si = stall_if_id_s; bb = bubble_s; fl = flush_s;
                     a = fa_s; b = fb_s; sc = int'(scnt_s); fc = int'(fcnt_s); end
      default: begin sp = stall_pc_f; si = stall_if_id_f; bb = bubble_f; fl = flush_f;
                     a = fa_f; b = fb_f; sc = int'(scnt_f); fc = int'(fcnt_f); end
    endcase
    compare("stall_pc", e.idx, int'(sp), int'(e.st));
    compare("stall_if_id", e.idx, int'(si), int'(e.st));
    compare("bubble_id_ex", e.idx, int'(bb), int'(e.bub));
    compare("flush_if_id", e.idx, int'(fl), int'(e.fl));
    compare("fwd_a_sel", e.idx, int'(a), int'(e.fa));
    compare("fwd_b_sel", e.idx, int'(b), int'(e.fb));
    if (e.scnt >= 0) compare("stall_cnt", e.idx, sc, e.scnt);
    if (e.fcnt >= 0) compare("flush_cnt", e.idx, fc, e.fcnt);
  endtask

  initial begin
    vec_t v;
    // Load-use, forwarding and priority (forwarding build)
    tbl.push_back(mk(0,1,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0, -1,-1));
    tbl.push_back(mk(0,1,0, 5,1,0,0, 0,0, 5,1,1, 0,0,0,0, 0,0,0,0,0,  0, 0));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,  0, 0));
    tbl.push_back(mk(0,0,0, 5,1,0,0, 0,0, 5,1,1, 0,0,0,0, 1,1,0,0,0,  0, 0));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 5,0, 0,0,0, 5,1,0,0, 0,0,0,1,0,  1, 0));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 5,5, 0,0,0, 0,0,5,1, 0,0,0,2,2,  1, 0));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0,7, 0,0,0, 7,1,7,1, 0,0,0,0,1,  1, 0));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0,7, 0,0,0, 7,0,7,1, 0,0,0,0,2,  1, 0));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 9,0, 0,0,0, 0,1,9,0, 0,0,0,0,0,  1, 0));
    tbl.push_back(mk(0,0,0, 12,0,12,1, 0,0, 12,1,1, 0,0,0,0, 1,1,0,0,0, 1, 0));
    tbl.push_back(mk(0,0,0, 0,1,0,1, 0,0, 0,1,1, 0,0,0,0, 0,0,0,0,0,  2, 0));
    tbl.push_back(mk(0,0,0, 6,1,0,0, 0,0, 6,1,0, 6,1,0,0, 0,0,0,0,0,  2, 0));
    // Redirect against hazard, SHADOW, redirect out of STALL
    tbl.push_back(mk(0,1,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0, -1,-1));
    tbl.push_back(mk(0,0,1, 5,1,0,0, 0,0, 5,1,1, 0,0,0,0, 0,1,1,0,0,  0, 0));
    tbl.push_back(mk(0,0,1, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,  0, 1));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,  0, 1));
    tbl.push_back(mk(0,0,0, 5,1,0,0, 0,0, 5,1,1, 0,0,0,0, 1,1,0,0,0,  0, 1));
    tbl.push_back(mk(0,0,1, 5,1,0,0, 0,0, 5,1,1, 0,0,0,0, 0,1,1,0,0,  1, 1));
    tbl.push_back(mk(0,0,1, 5,1,0,0, 0,0, 5,1,1, 0,0,0,0, 1,1,0,0,0,  1, 2));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,  2, 2));
    // Stalling build: EX then MEM match, released at WB
    tbl.push_back(mk(1,1,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0, -1,-1));
    tbl.push_back(mk(1,1,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,  0, 0));
    tbl.push_back(mk(1,0,0, 3,1,0,0, 4,0, 3,1,0, 4,1,0,0, 1,1,0,0,0,  0, 0));
    tbl.push_back(mk(1,0,0, 3,1,0,0, 0,3, 0,0,0, 3,1,0,0, 1,1,0,0,0,  1, 0));
    tbl.push_back(mk(1,0,0, 3,1,0,0, 0,0, 0,0,0, 0,0,3,1, 0,0,0,0,0,  2, 0));
    tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,  2, 0));
    // Reset in the middle of STALL and of SHADOW
    tbl.push_back(mk(0,1,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0, -1,-1));
    tbl.push_back(mk(0,0,0, 5,1,0,0, 0,0, 5,1,1, 0,0,0,0, 1,1,0,0,0,  0, 0));
    tbl.push_back(mk(0,0,0, 5,1,0,0, 0,0, 5,1,1, 0,0,0,0, 1,1,0,0,0,  1, 0));
    tbl.push_back(mk(0,1,1, 5,1,0,0, 5,5, 5,1,1, 5,1,5,1, 0,0,0,0,0,  2, 0));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,  0, 0));
    tbl.push_back(mk(0,0,1, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,1,1,0,0,  0, 0));
    tbl.push_back(mk(0,1,1, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,  0, 1));
    tbl.push_back(mk(0,0,1, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,1,1,0,0,  0, 0));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,  0, 1));

    $display("[TB] applying %0d table vectors", tbl.size());
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      v.idx = i;
      applyStimulus(v);
      checkOutput();
    end

    // Narrow counters: a held load-use hazard must pin stall_cnt at 15
    v = mk(2,1,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0, -1,-1);
    v.idx = 100; applyStimulus(v); checkOutput();
    v = mk(2,1,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0, 0, 0);
    v.idx = 101; applyStimulus(v); checkOutput();
    for (int i = 0; i < 22; i++) begin
      v = mk(2,0,0, 5,1,0,0, 0,0, 5,1,1, 0,0,0,0, 1,1,0,0,0, (i < 15) ? i : 15, 0);
      v.idx = 200 + i;
      applyStimulus(v);
      checkOutput();
    end
    v = mk(2,0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0, 15, 0);
    v.idx = 300; applyStimulus(v); checkOutput();

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_leftover got=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
